// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - sequential unsigned restoring divider, one quotient bit per cycle
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset; aborts any division and returns to idle
//   in_valid     operands on a/b are valid
//   in_ready     block is idle and can accept operands
//   a, b         dividend and divisor, unsigned, WORD_WIDTH bits
//   out_valid    q/r hold a completed result
//   out_ready    downstream consumes the result
//   q, r         quotient and remainder, held stable until consumed
//   div_by_zero  result came from b == 0 (only with DIV_BY_ZERO_FLAG_EN defined)
//
// Build option: DIV_BY_ZERO_FLAG_EN adds the div_by_zero flag and a fast path
// for a zero divisor that skips the trial subtractions.

module restoring_divider #(
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] a,
    input  logic [WORD_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] q,
    output logic [WORD_WIDTH-1:0] r
`ifdef DIV_BY_ZERO_FLAG_EN
    ,
    output logic                  div_by_zero
`endif
);

    localparam int CW = $clog2(WORD_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WORD_WIDTH-1:0] dividend;
    logic [WORD_WIDTH-1:0] divisor;
    logic [WORD_WIDTH-1:0] quot;
    // After every step the partial remainder is below the divisor, so the
    // stored value fits in WORD_WIDTH bits; the WORD_WIDTH+1 bit value only
    // exists as the shifted trial operand below.
    logic [WORD_WIDTH-1:0] rem;
    logic [CW-1:0]         count;
    logic [WORD_WIDTH-1:0] q_reg;
    logic [WORD_WIDTH-1:0] r_reg;

    logic [WORD_WIDTH:0]   rem_shift;
    logic [WORD_WIDTH-1:0] rem_diff;
    logic                  q_bit;
    logic [WORD_WIDTH-1:0] rem_step;
    logic [WORD_WIDTH-1:0] quot_step;
    logic                  last_step;
    logic                  zero_in;
    logic                  zero_held;

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift = {rem, dividend[WORD_WIDTH-1]};
        q_bit     = (rem_shift >= {1'b0, divisor});
        // Low bits of the difference are exact whenever the subtraction is taken.
        rem_diff  = rem_shift[WORD_WIDTH-1:0] - divisor;
        rem_step  = q_bit ? rem_diff : rem_shift[WORD_WIDTH-1:0];
        quot_step = (quot << 1) | WORD_WIDTH'(q_bit);
    end

    assign last_step = (count == CW'(1));

`ifdef DIV_BY_ZERO_FLAG_EN
    assign zero_in   = (b == '0);
    assign zero_held = (divisor == '0);
`else
    // Without the flag a zero divisor runs the full loop; the algorithm itself
    // produces q = all ones and r = a.
    assign zero_in   = 1'b0;
    assign zero_held = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (last_step) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Handshake outputs are pure decodes of the state register.
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign q         = q_reg;
    assign r         = r_reg;

    // Datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dividend <= '0;
            divisor  <= '0;
            quot     <= '0;
            rem      <= '0;
            count    <= '0;
            q_reg    <= '0;
            r_reg    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        dividend <= a;
                        divisor  <= b;
                        quot     <= '0;
                        rem      <= '0;
                        // A flagged zero divisor needs only a single pass
                        // through BUSY to publish its closed-form result.
                        count    <= zero_in ? CW'(1) : CW'(WORD_WIDTH);
                    end
                end
                S_BUSY: begin
                    dividend <= dividend << 1;
                    rem      <= rem_step;
                    quot     <= quot_step;
                    count    <= count - CW'(1);
                    if (last_step) begin
                        if (zero_held) begin
                            q_reg <= '1;
                            r_reg <= dividend;
                        end else begin
                            q_reg <= quot_step;
                            r_reg <= rem_step;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef DIV_BY_ZERO_FLAG_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_by_zero <= 1'b0;
        end else if (state == S_BUSY && last_step) begin
            div_by_zero <= zero_held;
        end else if (state == S_DONE && out_ready) begin
            div_by_zero <= 1'b0;
        end
    end
`endif

endmodule
